// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, constants and load encodings for the MEM/WB stage.
// Imported by the load aligner and the stage register.
package mem_wb_stage_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    localparam logic [XLEN-1:0]   ZERO_DATA = '0;
    localparam logic [XLEN-1:0]   ONE_DATA  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [REG_AW-1:0] ZERO_REG  = '0;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110,
        F3_ILL = 3'b111
    } load_f3_e;

    typedef struct packed {
        logic              valid;
        logic              rd_en;
        logic              fault;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load extraction, sign/zero extension and
// misalign / illegal-funct3 detection.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_offset,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data,
    output logic            o_fault
);

    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_sh;

    assign w_shamt = {i_offset, 3'b000};
    assign w_sh    = i_rdata >> w_shamt;

    always_comb begin
        o_data  = ZERO_DATA;
        o_fault = 1'b0;
        unique case (i_funct3)
            F3_LB: begin
                o_data = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
            end
            F3_LH: begin
                o_data  = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
                o_fault = i_offset[0];
            end
            F3_LW: begin
                o_data  = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
                o_fault = |i_offset[1:0];
            end
            F3_LD: begin
                o_data  = w_sh;
                o_fault = |i_offset;
            end
            F3_LBU: begin
                o_data = {{(XLEN-8){1'b0}}, w_sh[7:0]};
            end
            F3_LHU: begin
                o_data  = {{(XLEN-16){1'b0}}, w_sh[15:0]};
                o_fault = i_offset[0];
            end
            F3_LWU: begin
                o_data  = {{(XLEN-32){1'b0}}, w_sh[31:0]};
                o_fault = |i_offset[1:0];
            end
            default: begin
                o_fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: single entry, register-file write port,
// forwarding tap, load-fault pulse and retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              MemValid,
    output logic              MemReady,
    input  logic [REG_AW-1:0] MemRdAddr,
    input  logic              MemRdEn,
    input  logic [XLEN-1:0]   MemAluResult,
    input  logic [XLEN-1:0]   MemReadData,
    input  logic              MemLoadEn,
    input  logic [2:0]        MemLoadFunct3,
    input  logic [2:0]        MemAddrOffset,
    input  logic              Stall,
    input  logic              Flush,
    output logic [XLEN-1:0]   RdWriteData,
    output logic [REG_AW-1:0] RdWriteAddr,
    output logic              RdWriteEnable,
    output logic              WbFwdValid,
    output logic [REG_AW-1:0] WbFwdAddr,
    output logic [XLEN-1:0]   WbFwdData,
    output logic              LoadFault,
    output logic [XLEN-1:0]   Instret
);

    wb_entry_t       r_entry;
    logic            r_fault_pulse;
    logic [XLEN-1:0] r_instret;

    logic [XLEN-1:0] w_ld_data;
    logic            w_ld_fault;
    logic            w_fault;
    wb_entry_t       w_next;
    logic            w_wen;

    load_align u_load_align (
        .i_funct3 (MemLoadFunct3),
        .i_offset (MemAddrOffset),
        .i_rdata  (MemReadData),
        .o_data   (w_ld_data),
        .o_fault  (w_ld_fault)
    );

    assign MemReady = Rst & ~Stall;
    assign w_fault  = MemLoadEn & w_ld_fault;

    always_comb begin
        w_next         = '0;
        w_next.valid   = 1'b1;
        w_next.rd_en   = MemRdEn;
        w_next.fault   = w_fault;
        w_next.rd_addr = MemRdAddr;
        if (!w_fault)
            w_next.data = MemLoadEn ? w_ld_data : MemAluResult;
    end

    // Fault flag stays with a held entry to keep the write suppressed,
    // but the LoadFault pulse only lives for the capture cycle.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_entry       <= '0;
            r_fault_pulse <= 1'b0;
            r_instret     <= ZERO_DATA;
        end else if (Flush) begin
            r_entry.valid <= 1'b0;
            r_entry.fault <= 1'b0;
            r_fault_pulse <= 1'b0;
        end else if (Stall) begin
            r_fault_pulse <= 1'b0;
        end else if (MemValid) begin
            r_entry       <= w_next;
            r_fault_pulse <= w_fault;
            if (!w_fault)
                r_instret <= r_instret + ONE_DATA;
        end else begin
            r_entry.valid <= 1'b0;
            r_entry.fault <= 1'b0;
            r_fault_pulse <= 1'b0;
        end
    end

    assign w_wen = r_entry.valid & r_entry.rd_en & ~r_entry.fault
                 & (r_entry.rd_addr != ZERO_REG);

    assign RdWriteEnable = w_wen;
    assign RdWriteAddr   = r_entry.rd_addr;
    assign RdWriteData   = w_wen ? r_entry.data : ZERO_DATA;
    assign WbFwdValid    = w_wen;
    assign WbFwdAddr     = r_entry.rd_addr;
    assign WbFwdData     = w_wen ? r_entry.data : ZERO_DATA;
    assign LoadFault     = r_fault_pulse;
    assign Instret       = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        MemValid;
    logic        MemReady;
    logic [4:0]  MemRdAddr;
    logic        MemRdEn;
    logic [63:0] MemAluResult;
    logic [63:0] MemReadData;
    logic        MemLoadEn;
    logic [2:0]  MemLoadFunct3;
    logic [2:0]  MemAddrOffset;
    logic        Stall;
    logic        Flush;
    logic [63:0] RdWriteData;
    logic [4:0]  RdWriteAddr;
    logic        RdWriteEnable;
    logic        WbFwdValid;
    logic [4:0]  WbFwdAddr;
    logic [63:0] WbFwdData;
    logic        LoadFault;
    logic [63:0] Instret;

    int vecs = 0;
    int errs = 0;
    logic [63:0]  ir;
    logic [204:0] exp_o;
    logic [204:0] dut_o;

    localparam logic [63:0] RDATA = 64'h8877_6655_4433_2211;

    always #5 Clk = ~Clk;

    mem_wb_stage dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .MemValid      (MemValid),
        .MemReady      (MemReady),
        .MemRdAddr     (MemRdAddr),
        .MemRdEn       (MemRdEn),
        .MemAluResult  (MemAluResult),
        .MemReadData   (MemReadData),
        .MemLoadEn     (MemLoadEn),
        .MemLoadFunct3 (MemLoadFunct3),
        .MemAddrOffset (MemAddrOffset),
        .Stall         (Stall),
        .Flush         (Flush),
        .RdWriteData   (RdWriteData),
        .RdWriteAddr   (RdWriteAddr),
        .RdWriteEnable (RdWriteEnable),
        .WbFwdValid    (WbFwdValid),
        .WbFwdAddr     (WbFwdAddr),
        .WbFwdData     (WbFwdData),
        .LoadFault     (LoadFault),
        .Instret       (Instret)
    );

    assign dut_o = {RdWriteEnable, RdWriteAddr, RdWriteData, LoadFault,
                    Instret, WbFwdValid, WbFwdAddr, WbFwdData};

    task automatic put(input logic v, input logic [4:0] rd,
                       input logic [63:0] alu, input logic ld,
                       input logic [2:0] f3, input logic [2:0] off);
        MemValid      = v;
        MemRdAddr     = rd;
        MemRdEn       = 1'b1;
        MemAluResult  = alu;
        MemReadData   = RDATA;
        MemLoadEn     = ld;
        MemLoadFunct3 = f3;
        MemAddrOffset = off;
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
        put(1'b1, 5'd3, 64'hDEAD, 1'b0, 3'd0, 3'd0);
        #1;
        vecs++;
        if (MemReady !== 1'b0) begin
            errs++;
            $display("FAIL ready_in_reset: got %b want 0", MemReady);
        end
        cyc(); cyc();
        exp_o = '0;
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL reset_outputs: got %h want %h", dut_o, exp_o);
        end
        Rst = 1'b1;
        #1;
        vecs++;
        if (MemReady !== 1'b1) begin
            errs++;
            $display("FAIL ready_after_reset: got %b want 1", MemReady);
        end
        Stall = 1'b1;
        #1;
        vecs++;
        if (MemReady !== 1'b0) begin
            errs++;
            $display("FAIL ready_stall: got %b want 0", MemReady);
        end
        Stall = 1'b0;
        ir = 64'd0;
    endtask

    task automatic test_nonload();
        put(1'b1, 5'd5, 64'h1234, 1'b0, 3'd0, 3'd0);
        cyc();
        ir = ir + 1;
        exp_o = {1'b1, 5'd5, 64'h1234, 1'b0, ir, 1'b1, 5'd5, 64'h1234};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL nonload: got %h want %h", dut_o, exp_o);
        end
        put(1'b0, 5'd9, 64'h4321, 1'b0, 3'd0, 3'd0);
        cyc();
        exp_o = {1'b0, 5'd5, 64'd0, 1'b0, ir, 1'b0, 5'd5, 64'd0};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL bubble: got %h want %h", dut_o, exp_o);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [7];
        logic [2:0]  offs[7];
        logic [63:0] exps[7];
        f3s = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
        offs = '{3'd7, 3'd7, 3'd2, 3'd4, 3'd0, 3'd6, 3'd0};
        exps = '{64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'h4433,
                 64'hFFFF_FFFF_8877_6655, 64'h8877_6655_4433_2211,
                 64'h8877, 64'h4433_2211};
        for (int i = 0; i < 7; i++) begin
            put(1'b1, 5'd10, 64'hA5A5, 1'b1, f3s[i], offs[i]);
            cyc();
            ir = ir + 1;
            exp_o = {1'b1, 5'd10, exps[i], 1'b0, ir, 1'b1, 5'd10, exps[i]};
            vecs++;
            if (dut_o !== exp_o) begin
                errs++;
                $display("FAIL load%0d: got %h want %h", i, dut_o, exp_o);
            end
        end
    endtask

    task automatic test_fault();
        put(1'b1, 5'd7, 64'hA5A5, 1'b1, 3'b001, 3'd1);
        cyc();
        exp_o = {1'b0, 5'd7, 64'd0, 1'b1, ir, 1'b0, 5'd7, 64'd0};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL lh_misalign: got %h want %h", dut_o, exp_o);
        end
        put(1'b1, 5'd7, 64'hA5A5, 1'b1, 3'b111, 3'd0);
        cyc();
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL f3_illegal: got %h want %h", dut_o, exp_o);
        end
        put(1'b1, 5'd7, 64'hA5A5, 1'b1, 3'b010, 3'd2);
        cyc();
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL lw_misalign: got %h want %h", dut_o, exp_o);
        end
        Stall = 1'b1;
        cyc();
        exp_o = {1'b0, 5'd7, 64'd0, 1'b0, ir, 1'b0, 5'd7, 64'd0};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL fault_pulse_stall: got %h want %h", dut_o, exp_o);
        end
        Stall = 1'b0;
        put(1'b0, 5'd7, 64'hA5A5, 1'b0, 3'd0, 3'd0);
        cyc();
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL fault_clear: got %h want %h", dut_o, exp_o);
        end
    endtask

    task automatic test_rd0_stall();
        put(1'b1, 5'd0, 64'h55, 1'b0, 3'd0, 3'd0);
        cyc();
        ir = ir + 1;
        exp_o = {1'b0, 5'd0, 64'd0, 1'b0, ir, 1'b0, 5'd0, 64'd0};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL rd0: got %h want %h", dut_o, exp_o);
        end
        put(1'b1, 5'd3, 64'hABCD, 1'b0, 3'd0, 3'd0);
        cyc();
        ir = ir + 1;
        exp_o = {1'b1, 5'd3, 64'hABCD, 1'b0, ir, 1'b1, 5'd3, 64'hABCD};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL pre_stall: got %h want %h", dut_o, exp_o);
        end
        Stall = 1'b1;
        put(1'b1, 5'd12, 64'hFFFF, 1'b0, 3'd0, 3'd0);
        #1;
        vecs++;
        if (MemReady !== 1'b0) begin
            errs++;
            $display("FAIL ready_stalled: got %b want 0", MemReady);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            vecs++;
            if (dut_o !== exp_o) begin
                errs++;
                $display("FAIL stall_hold%0d: got %h want %h", i, dut_o, exp_o);
            end
        end
        Stall = 1'b0;
        put(1'b0, 5'd12, 64'hFFFF, 1'b0, 3'd0, 3'd0);
        cyc();
        exp_o = {1'b0, 5'd3, 64'd0, 1'b0, ir, 1'b0, 5'd3, 64'd0};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL post_stall: got %h want %h", dut_o, exp_o);
        end
    endtask

    task automatic test_flush();
        put(1'b1, 5'd4, 64'h77, 1'b0, 3'd0, 3'd0);
        cyc();
        ir = ir + 1;
        Stall = 1'b1; Flush = 1'b1;
        put(1'b1, 5'd6, 64'h66, 1'b0, 3'd0, 3'd0);
        cyc();
        exp_o = {1'b0, 5'd4, 64'd0, 1'b0, ir, 1'b0, 5'd4, 64'd0};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL flush_stall: got %h want %h", dut_o, exp_o);
        end
        Stall = 1'b0;
        cyc();
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL flush_capture: got %h want %h", dut_o, exp_o);
        end
        Flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        put(1'b1, 5'd9, 64'h99, 1'b0, 3'd0, 3'd0);
        cyc();
        Stall = 1'b1; Rst = 1'b0;
        cyc();
        exp_o = '0;
        vecs++;
        if (dut_o !== exp_o || MemReady !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid_stall: got %h want %h", dut_o, exp_o);
        end
        Stall = 1'b0; Rst = 1'b1;
        put(1'b1, 5'd7, 64'h0, 1'b1, 3'b010, 3'd1);
        cyc();
        Rst = 1'b0;
        cyc();
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL reset_mid_fault: got %h want %h", dut_o, exp_o);
        end
        Rst = 1'b1;
        put(1'b1, 5'd2, 64'h22, 1'b0, 3'd0, 3'd0);
        cyc();
        exp_o = {1'b1, 5'd2, 64'h22, 1'b0, 64'd1, 1'b1, 5'd2, 64'h22};
        vecs++;
        if (dut_o !== exp_o) begin
            errs++;
            $display("FAIL first_after_reset: got %h want %h", dut_o, exp_o);
        end
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_loads();
        test_fault();
        test_rd0_stall();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have: Clk  input  1  clock; all state updates on posedge Clk.
REQ-002 SHALL have: Rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: MemValid  input  1  upstream entry valid; MemReady  output  1  stage can accept.
REQ-004 SHALL have: MemRdAddr  input  5  destination register; MemRdEn  input  1  instruction writes rd.
REQ-005 SHALL have: MemAluResult  input  64  non-load result; MemReadData  input  64  raw aligned doubleword from data memory.
REQ-006 SHALL have: MemLoadEn  input  1  load instruction; MemLoadFunct3  input  3  load type; MemAddrOffset  input  3  byte offset in doubleword.
REQ-007 SHALL have: Stall  input  1  hold stage contents; Flush  input  1  squash held entry and the current capture.
REQ-008 SHALL have: RdWriteData  output  64; RdWriteAddr  output  5; RdWriteEnable  output  1 -- to register file write port.
REQ-009 SHALL have: WbFwdValid  output  1; WbFwdAddr  output  5; WbFwdData  output  64 -- to forwarding unit, equal to the write-port fields.
REQ-010 SHALL have: LoadFault  output  1  one-cycle pulse for misaligned or illegal load; Instret  output  64  retired count.

Function
REQ-011 SHALL hold a single-entry register (valid, rd addr, rd enable, data) loaded when MemValid && MemReady.
REQ-012 MemReady SHALL equal !Stall (combinational).
REQ-013 Latency SHALL be exactly 1 cycle: fields accepted at edge N appear on RdWrite*/WbFwd* after edge N.
REQ-014 Non-load: data SHALL be MemAluResult unchanged.
REQ-015 Load: data SHALL be extracted from MemReadData at byte MemAddrOffset: 000 LB, 001 LH, 010 LW, 011 LD sign-extend to 64; 100 LBU, 101 LHU, 110 LWU zero-extend.
REQ-016 Misaligned load (LH/LHU offset[0]=1; LW/LWU offset[1:0]!=0; LD offset!=0) or funct3=111 SHALL capture valid with write suppressed and assert LoadFault for that one output cycle.
REQ-017 RdWriteEnable SHALL be valid && rd enable && RdWriteAddr!=0 && !fault; WbFwdValid SHALL equal RdWriteEnable.
REQ-018 RdWriteData/WbFwdData SHALL be 0 whenever RdWriteEnable is 0.
REQ-019 Stall=1, Flush=0: entry SHALL be held and outputs repeat; no new capture; Instret not incremented for the repeat.
REQ-020 Flush=1 SHALL clear valid at the next edge regardless of Stall or MemValid (Flush wins over capture and over Stall).
REQ-021 MemValid=0 with MemReady=1 SHALL clear valid at the next edge (bubble).
REQ-022 Instret SHALL increment by 1 on each edge where a valid, non-faulting entry is first presented (counted once, not per stalled cycle); wraps modulo 2^64.
REQ-023 No combinational path SHALL exist from MemValid/data inputs to any output; only Stall->MemReady is combinational.

Reset
REQ-024 While Rst=0 at an edge: valid=0, rd addr=0, data=0, LoadFault=0, Instret=0; Stall/Flush/MemValid ignored.
REQ-025 Reset mid-stall or mid-fault SHALL discard the entry; first capture allowed on the first edge with Rst=1.
REQ-026 MemReady SHALL read 0 while Rst=0.

Structure
REQ-027 Data width (64), register-address width (5), zero constant and load funct3 codes SHALL come from the shared defines file; no local literals.
REQ-028 Load extraction and misalign/illegal detection SHALL be a combinational sub-module load_align, instanced once before the stage register.
REQ-029 Stage register, Instret counter and handshake logic SHALL live in mem_wb_stage; target 150-300 RTL lines total.

Verification
REQ-030 Non-load: MemValid=1, rd=5, MemAluResult=64'h1234 -> next cycle RdWriteEnable=1, addr=5, data=64'h1234, Instret=1.
REQ-031 Loads, MemReadData=64'h8877_6655_4433_2211: LB off7 -> 64'hFFFF_FFFF_FFFF_FF88; LBU off7 -> 64'h88; LH off2 -> 64'h4433; LW off4 -> 64'hFFFF_FFFF_8877_6655; LD off0 -> unchanged.
REQ-032 LH off1 or funct3=111, rd=7 -> RdWriteEnable=0, data=0, LoadFault=1 one cycle, Instret unchanged.
REQ-033 rd=0 with MemRdEn=1 -> RdWriteEnable=0, Instret+1; capture then Stall 3 cycles -> outputs held 4 cycles, Instret+1 only.
REQ-034 Stall=1 and Flush=1 with MemValid=1 -> next cycle RdWriteEnable=0; Rst=0 mid-stream -> all outputs 0, Instret=0.
